result_deskew_fifo: RTL and testbench
=====================================

Name: result_deskew_fifo

Overview:
- Successor to the systolic-array output deskew stage: accepts skewed per-column results with per-column valid tags instead of a global enable.
- Realigns each diagonal wavefront into a full result row, checks alignment, tags tile boundaries, and buffers rows in a FIFO.
- Hands rows downstream over a valid/ready handshake with backpressure.
- Sits between the PE grid's bottom/right output edge and the result writeback/DMA path.

Parameters:
N, 4, array dimension; number of result columns (N >= 1)
RESULT_WIDTH, 32, bits per result element
FIFO_DEPTH, 8, aligned rows buffered (power of 2, >= 2)
ROWS_PER_TILE, 4, rows per output tile, used for out_last (>= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  N  per-column valid; bit c qualifies column c
in_data  input  N*RESULT_WIDTH  skewed column results; column c at [c*RESULT_WIDTH +: RESULT_WIDTH]
out_valid  output  1  aligned row available at FIFO head
out_ready  input  1  downstream accepts the row
out_data  output  N*RESULT_WIDTH  aligned row; same packing as in_data
out_last  output  1  head row is the last row of a tile
level  output  $clog2(FIFO_DEPTH)+1  rows currently stored
overflow  output  1  sticky: a row was dropped because the FIFO was full
skew_error  output  1  sticky: aligned valids were partially set
clear_flags  input  1  clears overflow and skew_error

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset forces out_valid=0, out_last=0, out_data=0, level=0, overflow=0, skew_error=0.
- Reset also clears all delay stages (data and valid), FIFO pointers and the row counter. Reset mid-stream discards all in-flight data.
- Deskew: column c data and valid pass through N-1-c free-running registers. There is no enable: stages shift every cycle, and valid=0 bubbles travel with the data. Column N-1 has zero delay.
- Alignment: a row is complete in a cycle when all N delayed valids are 1. Write that row to the FIFO on the next edge.
- Partial alignment: if some but not all delayed valids are 1, set skew_error. Write nothing, and do not advance the row counter.
- Row counter: 0..ROWS_PER_TILE-1, increments per complete row and wraps to 0. The row written at count ROWS_PER_TILE-1 carries last=1.
- Full FIFO: a complete row arriving while the FIFO is full and no pop occurs that cycle is dropped and sets overflow. The row counter still advances, keeping tile framing intact.
- Push and pop in the same cycle are both performed; when full this is not an overflow. level is unchanged.
- FIFO is first-word-fall-through:
  - out_valid = (level != 0); out_data/out_last show the head entry.
  - Pop occurs on an edge with out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
- Pointers wrap modulo FIFO_DEPTH.
- level ranges 0..FIFO_DEPTH and is updated on the edge.
- Latency: if in_valid[0] is high in cycle t (and column c in cycle t+c) and the FIFO is empty, out_valid=1 in cycle t+N with that row. With N=1 the latency is 1 cycle.
- Sticky flags:
  - Set has priority over clear_flags in the same cycle.
  - clear_flags has no effect on the data path.
- out_data is 0 whenever level=0 after reset. Pops of an empty FIFO are ignored.

Test Plan:
- N=4, W=32, ready=1: inject row {1,2,3,4} skewed (col c valid in cycle t+c) -> out_valid in cycle t+4, out_data={1,2,3,4}, level returns to 0.
- Four back-to-back skewed rows, ROWS_PER_TILE=4 -> four consecutive output rows in order, out_last=1 only on the 4th; a 5th row has out_last=0.
- out_ready=0, inject 10 rows with FIFO_DEPTH=8 -> level saturates at 8, overflow=1, rows 9-10 dropped. Then ready=1 -> exactly rows 1-8 drain in order; the next tile's out_last position is unshifted.
- FIFO full with ready=1 and a new row arriving in the same cycle -> no overflow, level stays 8, order preserved.
- Drop in_valid[2] on one wavefront -> skew_error=1, no row written. clear_flags -> 0. Simultaneous error and clear_flags -> stays 1.
- Assert reset with 3 rows buffered and a wavefront half-injected -> next cycle out_valid=0, level=0, out_data=0. The remaining half-wavefront produces no row and no skew_error.

Source files
------------

// File: rtl/result_deskew_fifo.sv
// result_deskew_fifo
//   Realigns skewed per-column systolic-array results into full rows, checks
//   that each wavefront arrives complete, frames rows into tiles and buffers
//   them in a first-word-fall-through FIFO with a valid/ready output.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   in_valid[N]   per-column valid; bit c qualifies column c
//   in_data       skewed column results, column c at [c*RESULT_WIDTH +: RESULT_WIDTH]
//   out_valid     aligned row available at FIFO head
//   out_ready     downstream accepts the head row
//   out_data      head row, same packing as in_data (0 while empty)
//   out_last      head row is the last row of a tile
//   level         rows currently stored (0..FIFO_DEPTH)
//   overflow      sticky: a complete row was dropped because the FIFO was full
//   skew_error    sticky: a wavefront arrived with only some columns valid
//   clear_flags   clears overflow and skew_error (a set in the same cycle wins)
//
// Handshake: a row transfers on every rising edge where out_valid && out_ready.
// While out_valid=1 and out_ready=0 the head (out_data/out_last) holds stable.
module result_deskew_fifo #(
  parameter int N             = 4,
  parameter int RESULT_WIDTH  = 32,
  parameter int FIFO_DEPTH    = 8,
  parameter int ROWS_PER_TILE = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N-1:0]                   in_valid,
  input  logic [N*RESULT_WIDTH-1:0]      in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N*RESULT_WIDTH-1:0]      out_data,
  output logic                           out_last,
  output logic [$clog2(FIFO_DEPTH):0]    level,
  output logic                           overflow,
  output logic                           skew_error,
  input  logic                           clear_flags
);

  localparam int W   = RESULT_WIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int RW  = $clog2(ROWS_PER_TILE > 1 ? ROWS_PER_TILE : 2);
  localparam int WUW = $clog2(N) + 1;

  // Aligned (deskewed) view of the current wavefront.
  logic [N-1:0]   al_valid;
  logic [N*W-1:0] al_data;

  // Column c is delayed by N-1-c free-running stages so that all columns of a
  // wavefront meet in the same cycle. Bubbles (valid=0) travel with the data.
  for (genvar c = 0; c < N; c++) begin : g_col
    localparam int D = N - 1 - c;
    if (D == 0) begin : g_direct
      assign al_valid[c]       = in_valid[c];
      assign al_data[c*W +: W] = in_data[c*W +: W];
    end else begin : g_delay
      logic [D-1:0] v_sr;
      logic [W-1:0] d_sr [D];
      always_ff @(posedge clk) begin
        if (reset) begin
          v_sr <= '0;
          for (int k = 0; k < D; k++) d_sr[k] <= '0;
        end else begin
          v_sr[0] <= in_valid[c];
          d_sr[0] <= in_data[c*W +: W];
          for (int k = 1; k < D; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end
      assign al_valid[c]       = v_sr[D-1];
      assign al_data[c*W +: W] = d_sr[D-1];
    end
  end

  // After reset the delay lines have been flushed, but columns of a wavefront
  // that started before reset can still arrive for up to N-1 cycles. Those
  // leftovers are discarded without flagging a skew error.
  logic [WUW-1:0] warm_cnt;
  logic           warm_done;

  always_ff @(posedge clk) begin
    if (reset)               warm_cnt <= WUW'(N - 1);
    else if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
  end

  assign warm_done = (warm_cnt == '0);

  logic row_complete, row_partial;
  assign row_complete = warm_done && (&al_valid);
  assign row_partial  = warm_done && (|al_valid) && !(&al_valid);

  // Tile framing: the counter advances for every complete row, even one that
  // is dropped on overflow, so tile boundaries stay where the producer put them.
  logic [RW-1:0] row_cnt;
  logic          row_last;
  assign row_last = (row_cnt == RW'(ROWS_PER_TILE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
    end else if (row_complete) begin
      row_cnt <= row_last ? '0 : row_cnt + 1'b1;
    end
  end

  // FIFO storage and control.
  logic [N*W-1:0]        mem_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  full, push, pop, drop;

  assign full = (level == LW'(FIFO_DEPTH));
  assign pop  = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push = row_complete && (!full || pop);
  assign drop = row_complete && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= al_data;
      mem_last[wr_ptr] <= row_last;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    out_valid = (level != '0);
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = mem_data[rd_ptr];
      out_last = mem_last[rd_ptr];
    end
  end

  // Sticky flags: a new event in the same cycle beats clear_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      skew_error <= 1'b0;
    end else begin
      if (drop)             overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
      if (row_partial)      skew_error <= 1'b1;
      else if (clear_flags) skew_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_deskew_fifo.sv
// Testbench for result_deskew_fifo (N=4, 32-bit results, depth 8, 4 rows/tile).
// Stimulus is expressed as wavefronts: a wavefront launched in cycle t drives
// column c in cycle t+c. The reference model reasons about whole wavefronts:
// a wavefront completes in cycle t+N-1, becomes a row if every column was
// present, a skew error if only some were, and is discarded if a reset came
// at or after its launch. Rows go through a queue standing in for the FIFO.
module tb_result_deskew_fifo;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int RPT   = 4;
  localparam int MAXC  = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    reset = 1'b1;
  logic [N-1:0]            in_valid = '0;
  logic [N*W-1:0]          in_data = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [N*W-1:0]          out_data;
  logic                    out_last;
  logic [$clog2(DEPTH):0]  level;
  logic                    overflow;
  logic                    skew_error;
  logic                    clear_flags = 1'b0;

  result_deskew_fifo #(
    .N(N), .RESULT_WIDTH(W), .FIFO_DEPTH(DEPTH), .ROWS_PER_TILE(RPT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .level(level), .overflow(overflow), .skew_error(skew_error),
    .clear_flags(clear_flags)
  );

  // ---------------- stimulus plan ----------------
  logic [N-1:0] wf_mask [MAXC];
  logic [W-1:0] wf_base [MAXC];
  int           k = 0;
  logic         cur_reset = 1'b1;
  logic         cur_ready = 1'b0;
  logic         cur_clear = 1'b0;

  // ---------------- scoreboard / model ----------------
  logic [N*W:0] exp_q[$];   // {last, row data}
  int           m_rowcnt = 0;
  logic         m_ovf = 1'b0;
  logic         m_skew = 1'b0;
  int           last_reset = -100;
  int           n_cmp = 0;
  int           n_bad = 0;

  task automatic check_val(input string tag, input logic [N*W-1:0] got,
                           input logic [N*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // Launch a wavefront in the current cycle; column c carries base+c.
  task automatic launch(input logic [N-1:0] mask, input logic [W-1:0] base);
    if (k < MAXC) begin
      wf_mask[k] = mask;
      wf_base[k] = base;
    end
  endtask

  // Model update for the rising edge that ends cycle k.
  task automatic model_step();
    int           w;
    logic         pop, full_before, has_row, lst;
    logic [N-1:0] mask;
    logic [N*W-1:0] r;
    logic         set_ovf, set_skew;
    if (cur_reset) begin
      exp_q.delete();
      m_rowcnt   = 0;
      m_ovf      = 1'b0;
      m_skew     = 1'b0;
      last_reset = k;
    end else begin
      set_ovf     = 1'b0;
      set_skew    = 1'b0;
      has_row     = 1'b0;
      pop         = (exp_q.size() != 0) && cur_ready;
      full_before = (exp_q.size() == DEPTH);
      w = k - (N - 1);
      if (w >= 0 && w > last_reset) begin
        mask = wf_mask[w];
        if (&mask)      has_row  = 1'b1;
        else if (|mask) set_skew = 1'b1;
      end
      if (pop) void'(exp_q.pop_front());
      if (has_row) begin
        for (int c = 0; c < N; c++) r[c*W +: W] = wf_base[w] + W'(c);
        lst = (m_rowcnt == RPT - 1);
        m_rowcnt = (m_rowcnt + 1) % RPT;
        if (full_before && !pop) set_ovf = 1'b1;
        else exp_q.push_back({lst, r});
      end
      if (set_ovf)        m_ovf = 1'b1;
      else if (cur_clear) m_ovf = 1'b0;
      if (set_skew)       m_skew = 1'b1;
      else if (cur_clear) m_skew = 1'b0;
    end
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, step model.
  task automatic cycle();
    logic         ev;
    logic [N*W:0] head;
    int           idx;
    @(negedge clk);
    ev   = (exp_q.size() != 0);
    head = ev ? exp_q[0] : '0;
    check_val("out_valid",  N*W'(out_valid),  N*W'(ev));
    check_val("out_data",   out_data,         head[N*W-1:0]);
    check_val("out_last",   N*W'(out_last),   N*W'(head[N*W]));
    check_val("level",      N*W'(level),      N*W'(exp_q.size()));
    check_val("overflow",   N*W'(overflow),   N*W'(m_ovf));
    check_val("skew_error", N*W'(skew_error), N*W'(m_skew));
    for (int c = 0; c < N; c++) begin
      idx = k - c;
      if (idx >= 0 && idx < MAXC && wf_mask[idx][c]) begin
        in_valid[c]       = 1'b1;
        in_data[c*W +: W] = wf_base[idx] + W'(c);
      end else begin
        in_valid[c]       = 1'b0;
        in_data[c*W +: W] = $urandom;
      end
    end
    reset       = cur_reset;
    out_ready   = cur_ready;
    clear_flags = cur_clear;
    model_step();
    k++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rp;
    for (int i = 0; i < MAXC; i++) begin
      wf_mask[i] = '0;
      wf_base[i] = '0;
    end

    cur_reset = 1'b1;
    repeat (3) cycle();
    cur_reset = 1'b0;
    cur_ready = 1'b1;
    repeat (3) cycle();

    // Single row {1,2,3,4}, then drain.
    launch('1, 32'd1);
    repeat (10) cycle();

    // Five back-to-back rows: tile framing across a boundary.
    for (int i = 0; i < 5; i++) begin
      launch('1, 32'h100 + 32'(i * 16));
      cycle();
    end
    repeat (10) cycle();

    // Backpressure: ten rows into a depth-8 FIFO, then drain.
    cur_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      launch('1, 32'h1000 + 32'(i * 16));
      cycle();
    end
    repeat (6) cycle();
    cur_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      launch('1, 32'h2000 + 32'(i * 16));
      cycle();
    end
    repeat (16) cycle();
    cur_clear = 1'b1;
    cycle();
    cur_clear = 1'b0;

    // Full FIFO with a pop and a push on the same edge.
    cur_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      launch('1, 32'h3000 + 32'(i * 16));
      cycle();
    end
    repeat (4) cycle();
    cur_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      launch('1, 32'h4000 + 32'(i * 16));
      cycle();
    end
    repeat (16) cycle();

    // Skew error, clear, then error coinciding with clear.
    launch(4'b1011, 32'h5000);
    repeat (6) cycle();
    cur_clear = 1'b1;
    cycle();
    cur_clear = 1'b0;
    repeat (2) cycle();
    launch(4'b1011, 32'h5100);
    repeat (3) cycle();
    cur_clear = 1'b1;
    cycle();
    cur_clear = 1'b0;
    repeat (3) cycle();

    // Reset with three rows buffered and a wavefront half injected.
    cur_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      launch('1, 32'h6000 + 32'(i * 16));
      cycle();
    end
    repeat (4) cycle();
    launch('1, 32'h7000);
    repeat (2) cycle();
    cur_reset = 1'b1;
    cycle();
    cur_reset = 1'b0;
    repeat (8) cycle();
    cur_ready = 1'b1;
    repeat (2) cycle();

    // Randomized traffic.
    rp = 80;
    for (int i = 0; i < 2000; i++) begin
      if (i % 200 == 0) rp = $urandom_range(0, 100);
      cur_ready = ($urandom_range(0, 99) < rp);
      cur_clear = ($urandom_range(0, 49) == 0);
      cur_reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 99) < 65) begin
        if ($urandom_range(0, 19) == 0) launch(N'($urandom), $urandom);
        else launch('1, $urandom);
      end
      cycle();
    end
    cur_reset = 1'b0;
    cur_clear = 1'b0;
    cur_ready = 1'b1;
    repeat (20) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
